// File: rtl/ltc_lane_aligner.sv
// Word aligner and sample assembler for LTC-family multi-lane LVDS ADC receivers.
// Optional test-pattern checker enabled by defining LTC_TP_CHECK_EN.
module ltc_lane_aligner #(
    parameter int N_CH = 4,
    parameter int LANES = 2,
    parameter int S = 8,
    parameter logic [S-1:0] FRAME_PATTERN = 8'hF0,
    parameter int SETTLE = 2,
    parameter int LOCK_CNT = 64,
    parameter int ERR_TOL = 4,
    localparam int OFF_W = (S > 1) ? $clog2(S) : 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [S-1:0]              din_fr,
    input  logic [N_CH*LANES*S-1:0]   din_data,
    input  logic                      realign,
    input  logic [LANES*S-1:0]        tp_pattern,
    output logic [N_CH*LANES*S-1:0]   dout,
    output logic                      dout_valid,
    output logic                      locked,
    output logic                      align_fail,
    output logic [OFF_W-1:0]          slip_offset,
    output logic [7:0]                slip_count,
    output logic [15:0]               tp_err_cnt
);

    localparam int NL      = N_CH * LANES;
    localparam int DW      = NL * S;
    localparam int W       = LANES * S;
    localparam int MISS_W  = $clog2(S + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int ERR_W   = $clog2(ERR_TOL + 1);
    localparam int SET_W   = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_SETTLE, ST_VERIFY, ST_LOCKED} state_t;

    function automatic logic [S-1:0] window(input logic [S-1:0] prev, input logic [S-1:0] cur,
                                            input logic [OFF_W-1:0] off);
        logic [2*S-1:0] cat;
        cat = {prev, cur};
        return cat[2*S-1-int'(off) -: S];
    endfunction

    logic [S-1:0]  fr_cur, fr_prev, fr_win;
    logic [DW-1:0] data_cur, data_prev, data_win, data_al, sample_asm;
    logic [1:0]    fill;
    logic          fill_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fr_cur    <= '0;
            fr_prev   <= '0;
            data_cur  <= '0;
            data_prev <= '0;
            data_al   <= '0;
            dout      <= '0;
            fill      <= '0;
        end else begin
            fr_cur    <= din_fr;
            fr_prev   <= fr_cur;
            data_cur  <= din_data;
            data_prev <= data_cur;
            data_al   <= data_win;
            dout      <= sample_asm;
            if (!fill_done) fill <= fill + 2'd1;
        end
    end

    // The window needs both prev and cur populated before its first compare.
    assign fill_done = (fill == 2'd2);

    always_comb begin
        fr_win = window(fr_prev, fr_cur, slip_offset);
        data_win = '0;
        for (int l = 0; l < NL; l++)
            data_win[l*S +: S] = window(data_prev[l*S +: S], data_cur[l*S +: S], slip_offset);
    end

    generate
        if (LANES == 2) begin : g_two_lane
            always_comb begin
                sample_asm = '0;
                for (int c = 0; c < N_CH; c++)
                    for (int i = 0; i < S; i++) begin
                        sample_asm[c*W + 2*i + 1] = data_al[(2*c)*S + i];
                        sample_asm[c*W + 2*i]     = data_al[(2*c+1)*S + i];
                    end
            end
        end else begin : g_one_lane
            assign sample_asm = data_al;
        end
    endgenerate

    state_t             state, state_n;
    logic [OFF_W-1:0]   offset_n;
    logic [7:0]         slip_count_n;
    logic [MISS_W-1:0]  miss_run, miss_run_n;
    logic [MATCH_W-1:0] match_cnt, match_cnt_n;
    logic [ERR_W-1:0]   err_run, err_run_n;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_n;
    logic               locked_n, align_fail_n, frame_ok, do_slip;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_SEARCH;
            slip_offset <= '0;
            slip_count  <= '0;
            miss_run    <= '0;
            match_cnt   <= '0;
            err_run     <= '0;
            settle_cnt  <= '0;
            locked      <= 1'b0;
            align_fail  <= 1'b0;
            dout_valid  <= 1'b0;
        end else begin
            state       <= state_n;
            slip_offset <= offset_n;
            slip_count  <= slip_count_n;
            miss_run    <= miss_run_n;
            match_cnt   <= match_cnt_n;
            err_run     <= err_run_n;
            settle_cnt  <= settle_cnt_n;
            locked      <= locked_n;
            align_fail  <= align_fail_n;
            dout_valid  <= locked;
        end
    end

    // NOTE: every next-state signal gets a default first so the combinational block never infers a latch.
    always_comb begin
        state_n      = state;
        offset_n     = slip_offset;
        slip_count_n = slip_count;
        miss_run_n   = miss_run;
        match_cnt_n  = match_cnt;
        err_run_n    = err_run;
        settle_cnt_n = settle_cnt;
        locked_n     = locked;
        align_fail_n = align_fail;
        do_slip      = 1'b0;
        frame_ok     = (fr_win == FRAME_PATTERN);

        case (state)
            ST_SEARCH: begin
                if (fill_done) begin
                    if (!frame_ok) begin
                        do_slip = 1'b1;
                    end else if (LOCK_CNT <= 1) begin
                        state_n    = ST_LOCKED;
                        locked_n   = 1'b1;
                        miss_run_n = '0;
                        err_run_n  = '0;
                    end else begin
                        state_n     = ST_VERIFY;
                        match_cnt_n = MATCH_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE - 1)) begin
                    state_n      = ST_SEARCH;
                    settle_cnt_n = '0;
                end else begin
                    settle_cnt_n = settle_cnt + SET_W'(1);
                end
            end
            ST_VERIFY: begin
                if (!frame_ok) begin
                    do_slip = 1'b1;
                end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                    state_n    = ST_LOCKED;
                    locked_n   = 1'b1;
                    miss_run_n = '0;
                    err_run_n  = '0;
                end else begin
                    match_cnt_n = match_cnt + MATCH_W'(1);
                end
            end
            default: begin
                // Dropping lock keeps the offset so the known-good position is retried first.
                if (frame_ok) begin
                    err_run_n = '0;
                end else if (err_run == ERR_W'(ERR_TOL - 1)) begin
                    state_n     = ST_SEARCH;
                    locked_n    = 1'b0;
                    err_run_n   = '0;
                    match_cnt_n = '0;
                end else begin
                    err_run_n = err_run + ERR_W'(1);
                end
            end
        endcase

        if (do_slip) begin
            offset_n     = (slip_offset == OFF_W'(S - 1)) ? '0 : slip_offset + OFF_W'(1);
            slip_count_n = (slip_count == 8'hFF) ? slip_count : slip_count + 8'd1;
            if (miss_run != MISS_W'(S)) miss_run_n = miss_run + MISS_W'(1);
            if (miss_run >= MISS_W'(S - 1)) align_fail_n = 1'b1;
            match_cnt_n  = '0;
            settle_cnt_n = '0;
            state_n      = ST_SETTLE;
        end

        if (realign) begin
            state_n      = ST_SEARCH;
            offset_n     = '0;
            slip_count_n = '0;
            miss_run_n   = '0;
            match_cnt_n  = '0;
            err_run_n    = '0;
            settle_cnt_n = '0;
            locked_n     = 1'b0;
            align_fail_n = 1'b0;
        end
    end

`ifdef LTC_TP_CHECK_EN
    logic [16:0] tp_sum;

    always_comb begin
        tp_sum = {1'b0, tp_err_cnt};
        for (int c = 0; c < N_CH; c++)
            if (dout[c*W +: W] != tp_pattern) tp_sum = tp_sum + 17'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            tp_err_cnt <= '0;
        else if (realign)
            tp_err_cnt <= '0;
        else if (dout_valid)
            tp_err_cnt <= tp_sum[16] ? 16'hFFFF : tp_sum[15:0];
    end
`else
    logic tp_unused;
    assign tp_unused  = ^tp_pattern;
    assign tp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ltc_lane_aligner.sv
// Directed bench for ltc_lane_aligner: reset, lock, slip/offset search, error tolerance,
// realign priority, stuck frame lane and test-pattern counting.
module tb_ltc_lane_aligner;

    localparam int N_CH = 4;
    localparam int LANES = 2;
    localparam int S = 8;
    localparam int W = LANES * S;
    localparam int DW = N_CH * W;
    localparam int LOCK_CNT = 64;
`ifdef LTC_TP_CHECK_EN
    localparam int TP_EXP = 5;
`else
    localparam int TP_EXP = 0;
`endif

    logic            sys_clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic [S-1:0]    din_fr;
    logic [DW-1:0]   din_data;
    logic            realign;
    logic [W-1:0]    tp_pattern;
    logic [DW-1:0]   dout;
    logic            dout_valid, locked, align_fail;
    logic [2:0]      slip_offset;
    logic [7:0]      slip_count;
    logic [15:0]     tp_err_cnt;

    int checks = 0;
    int failures = 0;

    ltc_lane_aligner #(.N_CH(N_CH), .LANES(LANES), .S(S), .FRAME_PATTERN(8'hF0),
                       .SETTLE(2), .LOCK_CNT(LOCK_CNT), .ERR_TOL(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din_fr(din_fr), .din_data(din_data),
        .realign(realign), .tp_pattern(tp_pattern), .dout(dout), .dout_valid(dout_valid),
        .locked(locked), .align_fail(align_fail), .slip_offset(slip_offset),
        .slip_count(slip_count), .tp_err_cnt(tp_err_cnt));

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Rotate right: a repeating lane word seen d bits late in the continuous bitstream.
    function automatic logic [7:0] ror8(input logic [7:0] v, input int d);
        logic [15:0] t;
        t = {v, v};
        return t[d +: 8];
    endfunction

    task automatic drive(input logic [7:0] fr, input logic [3:0][7:0] a,
                         input logic [3:0][7:0] b, input int d);
        din_fr = ror8(fr, d);
        for (int c = 0; c < N_CH; c++) begin
            din_data[(2*c)*S +: S]   = ror8(a[c], d);
            din_data[(2*c+1)*S +: S] = ror8(b[c], d);
        end
    endtask

    task automatic pulse_realign();
        realign = 1'b1;
        @(negedge sys_clk);
        realign = 1'b0;
    endtask

    task automatic wait_lock(input string name, input int bound);
        int cyc;
        cyc = 0;
        while (!locked && cyc < bound) begin
            @(negedge sys_clk);
            cyc++;
        end
        check(name, 64'(locked), 64'd1);
    endtask

    typedef struct {
        int               d;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int  cyc;
        bit  stayed, saw7, ever_locked;

        vecs[0] = '{d: 0, a: {4{8'h6B}}, b: {4{8'h7C}}, exp: {4{16'h3DDA}}};
        vecs[1] = '{d: 3, a: {4{8'h6B}}, b: {4{8'h7C}}, exp: {4{16'h3DDA}}};
        vecs[2] = '{d: 5, a: {8'h80, 8'h6B, 8'h00, 8'hFF}, b: {8'h01, 8'h7C, 8'hFF, 8'h00},
                    exp: {16'h8001, 16'h3DDA, 16'h5555, 16'hAAAA}};
        vecs[3] = '{d: 7, a: {4{8'h0F}}, b: {4{8'hF0}}, exp: {4{16'h55AA}}};

        realign = 1'b0;
        tp_pattern = 16'h3DDA;
        drive(8'hF0, {4{8'h6B}}, {4{8'h7C}}, 0);
        repeat (3) @(negedge sys_clk);

        check("rst_locked", 64'(locked), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_slip_offset", 64'(slip_offset), 64'd0);
        check("rst_slip_count", 64'(slip_count), 64'd0);
        check("rst_align_fail", 64'(align_fail), 64'd0);
        check("rst_tp_err_cnt", 64'(tp_err_cnt), 64'd0);

        // Aligned stream: two fill cycles, then LOCK_CNT matching compares.
        sys_rst_n = 1'b1;
        cyc = 0;
        while (!locked && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("lock_latency", 64'(cyc), 64'(LOCK_CNT + 2));
        check("aligned_slip_count", 64'(slip_count), 64'd0);
        check("valid_lags_locked", 64'(dout_valid), 64'd0);
        @(negedge sys_clk);
        check("aligned_dout_valid", 64'(dout_valid), 64'd1);
        check("aligned_dout", dout, {4{16'h3DDA}});

        // Three bad frame words stay within tolerance.
        din_fr = 8'h00;
        repeat (3) @(negedge sys_clk);
        din_fr = 8'hF0;
        stayed = 1'b1;
        repeat (8) begin
            @(negedge sys_clk);
            if (!locked) stayed = 1'b0;
        end
        check("tol3_stays_locked", 64'(stayed), 64'd1);

        // Four bad frame words: lock drops on the fourth mismatching compare.
        din_fr = 8'h00;
        repeat (4) @(negedge sys_clk);
        din_fr = 8'hF0;
        @(negedge sys_clk);
        check("tol4_third_err_locked", 64'(locked), 64'd1);
        @(negedge sys_clk);
        check("tol4_fourth_err_drop", 64'(locked), 64'd0);
        wait_lock("tol4_relock", 200);
        check("tol4_relock_slip_count", 64'(slip_count), 64'd0);
        check("tol4_relock_offset", 64'(slip_offset), 64'd0);

        for (int v = 0; v < 4; v++) begin
            drive(8'hF0, vecs[v].a, vecs[v].b, vecs[v].d);
            repeat (3) @(negedge sys_clk);
            pulse_realign();
            wait_lock($sformatf("vec%0d_lock", v), 300);
            repeat (4) @(negedge sys_clk);
            check($sformatf("vec%0d_offset", v), 64'(slip_offset), 64'(vecs[v].d));
            check($sformatf("vec%0d_slip_count", v), 64'(slip_count), 64'(vecs[v].d));
            check($sformatf("vec%0d_align_fail", v), 64'(align_fail), 64'd0);
            check($sformatf("vec%0d_dout_valid", v), 64'(dout_valid), 64'd1);
            for (int c = 0; c < N_CH; c++)
                check($sformatf("vec%0d_dout_ch%0d", v, c), 64'(dout[c*W +: W]),
                      64'(vecs[v].exp[c]));
        end

        // Realign coincides with a frame mismatch while locked at offset 7.
        din_fr = 8'h00;
        @(negedge sys_clk);
        check("pre_realign_locked", 64'(locked), 64'd1);
        pulse_realign();
        check("realign_locked", 64'(locked), 64'd0);
        check("realign_offset", 64'(slip_offset), 64'd0);
        check("realign_slip_count", 64'(slip_count), 64'd0);
        check("realign_align_fail", 64'(align_fail), 64'd0);

        // Frame lane stuck at zero: search wraps and align_fail sets on the 8th slip.
        saw7 = 1'b0;
        ever_locked = 1'b0;
        cyc = 0;
        while (!align_fail && cyc < 100) begin
            @(negedge sys_clk);
            cyc++;
            if (slip_offset == 3'd7) saw7 = 1'b1;
            if (locked) ever_locked = 1'b1;
        end
        check("stuck_align_fail", 64'(align_fail), 64'd1);
        check("stuck_slip_count", 64'(slip_count), 64'd8);
        check("stuck_offset_wrapped", 64'(slip_offset), 64'd0);
        check("stuck_saw_offset7", 64'(saw7), 64'd1);
        check("stuck_never_locked", 64'(ever_locked), 64'd0);
        repeat (9) @(negedge sys_clk);
        check("stuck_fail_sticky", 64'(align_fail), 64'd1);
        check("stuck_search_continues", 64'(slip_count), 64'd11);
        check("stuck_offset_after", 64'(slip_offset), 64'd3);

        // Test-pattern counting: channel 2 a-lane corrupted for five locked cycles.
        drive(8'hF0, {4{8'h6B}}, {4{8'h7C}}, 0);
        repeat (3) @(negedge sys_clk);
        pulse_realign();
        wait_lock("tp_lock", 200);
        repeat (4) @(negedge sys_clk);
        check("tp_clean", 64'(tp_err_cnt), 64'd0);
        din_data[(2*2)*S +: S] = 8'h00;
        repeat (5) @(negedge sys_clk);
        din_data[(2*2)*S +: S] = 8'h6B;
        repeat (6) @(negedge sys_clk);
        check("tp_err_count", 64'(tp_err_cnt), 64'(TP_EXP));
        check("tp_still_locked", 64'(locked), 64'd1);
        pulse_realign();
        check("tp_realign_clear", 64'(tp_err_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
